// File: rtl/video_line_delay_if.sv
// Video stream bundle: the raw source stream in and the regenerated VGA-side stream out.
interface video_line_delay_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 4
);
    logic [PIX_W-1:0] in_r;
    logic [PIX_W-1:0] in_g;
    logic [PIX_W-1:0] in_b;
    logic             in_de;
    logic             in_hs;
    logic             in_vs;
    logic [OUT_W-1:0] out_r;
    logic [OUT_W-1:0] out_g;
    logic [OUT_W-1:0] out_b;
    logic             out_de;
    logic             out_hs;
    logic             out_vs;

    // Source side drives the input stream and observes the output stream.
    modport master (
        output in_r, in_g, in_b, in_de, in_hs, in_vs,
        input  out_r, out_g, out_b, out_de, out_hs, out_vs
    );

    // The line-delay block consumes the input stream and drives the output stream.
    modport slave (
        input  in_r, in_g, in_b, in_de, in_hs, in_vs,
        output out_r, out_g, out_b, out_de, out_hs, out_vs
    );
endinterface

// File: rtl/video_line_delay.sv
// video_line_delay: stores active pixels in a circular multi-line buffer and
// regenerates the stream either live or DELAY_LINES lines late, with optional
// grayscale/brightness processing. Also measures incoming line width and frame height.
module video_line_delay #(
    parameter int PIX_W       = 8,
    parameter int OUT_W       = 4,
    parameter int H_ACTIVE    = 800,
    parameter int DELAY_LINES = 2
) (
    input  logic              pclk,
    input  logic              rst_n,
    video_line_delay_if.slave vid,
    input  logic [1:0]        mode,
    input  logic [3:0]        bright,
    output logic [15:0]       meas_width,
    output logic [15:0]       meas_height,
    output logic              line_err
);
    localparam int NLINES = DELAY_LINES + 1;
    localparam int DEPTH  = NLINES * H_ACTIVE;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int X_W    = $clog2(H_ACTIVE + 1);
    localparam int LN_W   = $clog2(NLINES);
    localparam int WORD_W = 3 * OUT_W;
    localparam int SUM_W  = OUT_W + 2;

    localparam logic [X_W-1:0]   X_MAX     = X_W'(H_ACTIVE);
    localparam logic [LN_W-1:0]  LAST_LINE = LN_W'(DELAY_LINES);
    localparam logic [15:0]      DLY16     = 16'(DELAY_LINES);
    localparam logic [ADDR_W-1:0] H_ADDR   = ADDR_W'(H_ACTIVE);
    localparam logic [SUM_W-1:0] THREE     = SUM_W'(3);

    typedef enum logic [1:0] {SRC_LIVE, SRC_BLACK, SRC_MEM} src_e;

    // Front-end state
    logic [X_W-1:0]   x_q, x_d;
    logic [15:0]      line_cnt_q, line_cnt_d;
    logic [LN_W-1:0]  wr_line_q, wr_line_d;
    logic [15:0]      meas_width_q, meas_width_d;
    logic [15:0]      meas_height_q, meas_height_d;
    logic             line_err_q, line_err_d;
    logic [1:0]       mode_act_q, mode_act_d;
    logic [OUT_W-1:0] bright_act_q, bright_act_d;
    logic             de_q, vs_q;

    // Stage 1 (source selection, memory read, control delay)
    src_e             src_q, src_d;
    logic [WORD_W-1:0] live_q;
    logic [WORD_W-1:0] rd_data_q;
    logic             de1_q, hs1_q, vs1_q, gray1_q;
    logic [OUT_W-1:0] bright1_q;

    // Stage 2 (grayscale, blanking, output register)
    logic [OUT_W-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
    logic             out_de_q, out_hs_q, out_vs_q;

    // Memory and address path
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] pix_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [LN_W-1:0]   rd_line;
    logic [X_W-1:0]    rd_x;

    // Stage 2 working signals
    logic [WORD_W-1:0] pix;
    logic [OUT_W-1:0]  ch_r, ch_g, ch_b, gray_adj;
    logic [SUM_W-1:0]  sum, gray;

    // Only the upper OUT_W bits of each input channel are kept.
    logic unused_in_lsbs;
    assign unused_in_lsbs = ^{vid.in_r, vid.in_g, vid.in_b};

    assign pix_in = {vid.in_r[PIX_W-1 -: OUT_W], vid.in_g[PIX_W-1 -: OUT_W],
                     vid.in_b[PIX_W-1 -: OUT_W]};

    // Pixel position, line/frame bookkeeping, geometry measurement and frame-aligned mode latch.
    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave it unassigned and infer a latch.
        x_d           = x_q;
        line_cnt_d    = line_cnt_q;
        wr_line_d     = wr_line_q;
        meas_width_d  = meas_width_q;
        meas_height_d = meas_height_q;
        line_err_d    = line_err_q;
        mode_act_d    = mode_act_q;
        bright_act_d  = bright_act_q;

        if (vid.in_de) begin
            if (x_q == X_MAX) line_err_d = 1'b1;
            else              x_d = x_q + 1'b1;
        end else begin
            x_d = '0;
        end

        if (de_q && !vid.in_de) begin
            meas_width_d = 16'(x_q);
            if (line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
            wr_line_d = (wr_line_q == LAST_LINE) ? '0 : wr_line_q + 1'b1;
        end

        // Vertical sync restarts line numbering; it overrides the DE-fall advance above.
        if (!vid.in_vs) begin
            line_cnt_d   = '0;
            wr_line_d    = '0;
            mode_act_d   = mode;
            bright_act_d = OUT_W'(bright);
            if (vs_q) meas_height_d = line_cnt_q;
        end
    end

    // Front-end registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            line_cnt_q    <= '0;
            wr_line_q     <= '0;
            meas_width_q  <= '0;
            meas_height_q <= '0;
            line_err_q    <= 1'b0;
            mode_act_q    <= '0;
            bright_act_q  <= '0;
            de_q          <= 1'b0;
            vs_q          <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
            x_q           <= x_d;
            line_cnt_q    <= line_cnt_d;
            wr_line_q     <= wr_line_d;
            meas_width_q  <= meas_width_d;
            meas_height_q <= meas_height_d;
            line_err_q    <= line_err_d;
            mode_act_q    <= mode_act_d;
            bright_act_q  <= bright_act_d;
            de_q          <= vid.in_de;
            vs_q          <= vid.in_vs;
        end
    end

    // Write/read addressing and source choice; the read slot is the line written DELAY_LINES lines ago.
    always_comb begin
        wr_en   = vid.in_de && (x_q != X_MAX);
        wr_addr = ADDR_W'(wr_line_q) * H_ADDR + ADDR_W'(x_q);
        rd_line = (wr_line_q == LAST_LINE) ? '0 : wr_line_q + 1'b1;
        rd_x    = (x_q == X_MAX) ? X_MAX - 1'b1 : x_q;
        rd_addr = ADDR_W'(rd_line) * H_ADDR + ADDR_W'(rd_x);
        src_d   = SRC_LIVE;
        if (mode_act_q[0]) src_d = (line_cnt_q < DLY16) ? SRC_BLACK : SRC_MEM;
    end

    // Line buffer: one write port, one synchronous read port.
    always_ff @(posedge pclk) begin
        // NOTE: the pixel store is deliberately not reset; lines are always rewritten before a valid read.
        if (wr_en) mem[wr_addr] <= pix_in;
        rd_data_q <= mem[rd_addr];
    end

    // Grayscale, brightness subtraction and blanking for the output register.
    always_comb begin
        unique case (src_q)
            SRC_LIVE: pix = live_q;
            SRC_MEM:  pix = rd_data_q;
            default:  pix = '0;
        endcase
        ch_r     = pix[WORD_W-1 -: OUT_W];
        ch_g     = pix[2*OUT_W-1 -: OUT_W];
        ch_b     = pix[OUT_W-1:0];
        sum      = SUM_W'(ch_r) + SUM_W'(ch_g) + SUM_W'(ch_b);
        gray     = sum / THREE;
        gray_adj = (gray > SUM_W'(bright1_q)) ? OUT_W'(gray - SUM_W'(bright1_q)) : '0;
        out_r_d  = ch_r;
        out_g_d  = ch_g;
        out_b_d  = ch_b;
        if (gray1_q) begin
            out_r_d = gray_adj;
            out_g_d = gray_adj;
            out_b_d = gray_adj;
        end
        if (!de1_q) begin
            out_r_d = '0;
            out_g_d = '0;
            out_b_d = '0;
        end
    end

    // Two-stage output pipeline; colour and syncs share the same latency.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= SRC_BLACK;
            live_q    <= '0;
            de1_q     <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            gray1_q   <= 1'b0;
            bright1_q <= '0;
            out_r_q   <= '0;
            out_g_q   <= '0;
            out_b_q   <= '0;
            out_de_q  <= 1'b0;
            out_hs_q  <= 1'b1;
            out_vs_q  <= 1'b1;
        end else begin
            src_q     <= src_d;
            live_q    <= pix_in;
            de1_q     <= vid.in_de;
            hs1_q     <= vid.in_hs;
            vs1_q     <= vid.in_vs;
            gray1_q   <= mode_act_q[1];
            bright1_q <= bright_act_q;
            out_r_q   <= out_r_d;
            out_g_q   <= out_g_d;
            out_b_q   <= out_b_d;
            out_de_q  <= de1_q;
            out_hs_q  <= hs1_q;
            out_vs_q  <= vs1_q;
        end
    end

    assign vid.out_r   = out_r_q;
    assign vid.out_g   = out_g_q;
    assign vid.out_b   = out_b_q;
    assign vid.out_de  = out_de_q;
    assign vid.out_hs  = out_hs_q;
    assign vid.out_vs  = out_vs_q;
    assign meas_width  = meas_width_q;
    assign meas_height = meas_height_q;
    assign line_err    = line_err_q;
endmodule

// File: tb/tb_video_line_delay.sv
// Testbench for video_line_delay: random video stimulus compared cycle by cycle
// against a frame-history reference model, plus directed geometry and reset checks.
module tb_video_line_delay;
    localparam int PIX_W       = 8;
    localparam int OUT_W       = 4;
    localparam int H_ACTIVE    = 8;
    localparam int DELAY_LINES = 2;
    localparam int MAXL        = 64;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  bright = 4'd0;
    logic [15:0] meas_width, meas_height;
    logic        line_err;

    video_line_delay_if #(.PIX_W(PIX_W), .OUT_W(OUT_W)) vid ();

    video_line_delay #(
        .PIX_W(PIX_W), .OUT_W(OUT_W), .H_ACTIVE(H_ACTIVE), .DELAY_LINES(DELAY_LINES)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vid(vid), .mode(mode), .bright(bright),
        .meas_width(meas_width), .meas_height(meas_height), .line_err(line_err)
    );

    always #5 pclk = ~pclk;

    typedef struct packed { logic [14:0] exp; logic [14:0] mask; } pend_t;
    typedef struct packed { logic [14:0] exp; logic [14:0] obs; logic [14:0] mask; } res_t;

    pend_t pend_q[$];
    res_t  res_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference model: the current frame as a list of lines indexed by line number.
    logic [11:0] fbuf   [MAXL][H_ACTIVE];
    bit          fvalid [MAXL][H_ACTIVE];
    int          m_x, m_lines, m_width, m_height;
    bit          m_err, m_prev_de, m_prev_vs;
    logic [1:0]  m_mode;
    logic [3:0]  m_bright;

    task automatic clear_frame();
        for (int l = 0; l < MAXL; l++)
            for (int i = 0; i < H_ACTIVE; i++) fvalid[l][i] = 1'b0;
    endtask

    task automatic model_reset();
        m_x = 0; m_lines = 0; m_width = 0; m_height = 0; m_err = 1'b0;
        m_prev_de = 1'b0; m_prev_vs = 1'b1; m_mode = 2'd0; m_bright = 4'd0;
        clear_frame();
        pend_q.delete();
        res_q.delete();
    endtask

    // Expected output for one input sample, then advance the model by that sample.
    task automatic model_step(input bit de, hs, vs, input logic [7:0] r, g, b);
        logic [11:0] px, src, col;
        logic [3:0]  g4;
        bit          known;
        int          s, gy, old_lines;
        pend_t       p;
        px = {r[PIX_W-1 -: OUT_W], g[PIX_W-1 -: OUT_W], b[PIX_W-1 -: OUT_W]};
        known = 1'b1;
        src = '0;
        if (!m_mode[0]) src = px;
        else if (m_lines < DELAY_LINES) src = '0;
        else if (m_x >= H_ACTIVE || m_lines - DELAY_LINES >= MAXL ||
                 !fvalid[m_lines - DELAY_LINES][m_x]) known = 1'b0;
        else src = fbuf[m_lines - DELAY_LINES][m_x];
        col = src;
        if (m_mode[1]) begin
            s  = int'(src[11:8]) + int'(src[7:4]) + int'(src[3:0]);
            gy = s / 3;
            gy = (gy > int'(m_bright)) ? gy - int'(m_bright) : 0;
            g4 = 4'(gy);
            col = {g4, g4, g4};
        end
        if (!de) begin
            col = '0;
            known = 1'b1;
        end
        p.exp  = {de, hs, vs, col};
        p.mask = known ? 15'h7FFF : 15'h7000;
        pend_q.push_back(p);

        old_lines = m_lines;
        if (de) begin
            if (m_x < H_ACTIVE) begin
                if (m_lines < MAXL) begin
                    fbuf[m_lines][m_x]   = px;
                    fvalid[m_lines][m_x] = 1'b1;
                end
                m_x++;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            if (m_prev_de) begin
                m_width = m_x;
                if (m_lines < 65535) m_lines++;
            end
            m_x = 0;
        end
        if (!vs) begin
            if (m_prev_vs) begin
                m_height = old_lines;
                clear_frame();
            end
            m_lines  = 0;
            m_mode   = mode;
            m_bright = bright;
        end
        m_prev_de = de;
        m_prev_vs = vs;
    endtask

    // One pixel clock: drive at the falling edge, model at the rising edge, observe at the next falling edge.
    task automatic tick(input bit de, hs, vs, input logic [7:0] r, g, b);
        pend_t p;
        res_t  q;
        vid.in_de = de; vid.in_hs = hs; vid.in_vs = vs;
        vid.in_r = r; vid.in_g = g; vid.in_b = b;
        @(posedge pclk);
        model_step(de, hs, vs, r, g, b);
        @(negedge pclk);
        if (pend_q.size() == 2) begin
            p = pend_q.pop_front();
            q.exp  = p.exp;
            q.mask = p.mask;
            q.obs  = {vid.out_de, vid.out_hs, vid.out_vs, vid.out_r, vid.out_g, vid.out_b};
            res_q.push_back(q);
        end
    endtask

    // One line with horizontal blanking; a negative channel value means random.
    task automatic line(input int npix, input int rv, input int gv, input int bv);
        repeat (2) tick(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        repeat (2) tick(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < npix; i++)
            tick(1'b1, 1'b1, 1'b1,
                 (rv < 0) ? 8'($urandom) : 8'(rv),
                 (gv < 0) ? 8'($urandom) : 8'(gv),
                 (bv < 0) ? 8'($urandom) : 8'(bv));
        tick(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic vsync();
        repeat (3) tick(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        obs = {vid.out_de, vid.out_hs, vid.out_vs, vid.out_r, vid.out_g, vid.out_b};
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 12'h000}) $display("FAIL reset_stream: got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 12'h000});
        else n_pass++;
        n_checks++;
        if ({meas_width, meas_height, line_err} !== 33'd0)
            $display("FAIL reset_meas: got w=%0d h=%0d err=%b expected 0 0 0", meas_width, meas_height, line_err);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_live();
        res_t q;
        mode = 2'd0;
        line(8, 8'hA5, -1, -1);
        repeat (2) tick(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        while (res_q.size() > 0) begin
            q = res_q.pop_front();
            n_checks++;
            if ((q.obs & q.mask) !== (q.exp & q.mask)) $display("FAIL live_stream: got %h expected %h", q.obs, q.exp);
            else n_pass++;
        end
        n_checks++;
        if (meas_width !== 16'd8) $display("FAIL live_width: got %0d expected 8", meas_width);
        else n_pass++;
    endtask

    task automatic test_delay();
        res_t q;
        mode = 2'd1;
        vsync();
        for (int l = 0; l < 4; l++) line(8, l << 4, -1, -1);
        vsync();
        n_checks++;
        if (meas_height !== 16'd4) $display("FAIL delay_height4: got %0d expected 4", meas_height);
        else n_pass++;
        for (int l = 0; l < 5; l++) line(8, -1, -1, -1);
        vsync();
        n_checks++;
        if (meas_height !== 16'd5) $display("FAIL delay_height5: got %0d expected 5", meas_height);
        else n_pass++;
        while (res_q.size() > 0) begin
            q = res_q.pop_front();
            n_checks++;
            if ((q.obs & q.mask) !== (q.exp & q.mask)) $display("FAIL delay_stream: got %h expected %h", q.obs, q.exp);
            else n_pass++;
        end
    endtask

    task automatic test_overlength();
        res_t q;
        mode = 2'd1;
        vsync();
        line(10, -1, -1, -1);
        n_checks++;
        if (meas_width !== 16'd8 || line_err !== 1'b1)
            $display("FAIL overlength_meas: got w=%0d err=%b expected w=8 err=1", meas_width, line_err);
        else n_pass++;
        line(8, -1, -1, -1);
        line(8, -1, -1, -1);
        vsync();
        line(6, -1, -1, -1);
        n_checks++;
        if (line_err !== 1'b1 || meas_width !== 16'd6)
            $display("FAIL overlength_sticky: got err=%b w=%0d expected err=1 w=6", line_err, meas_width);
        else n_pass++;
        while (res_q.size() > 0) begin
            q = res_q.pop_front();
            n_checks++;
            if ((q.obs & q.mask) !== (q.exp & q.mask)) $display("FAIL overlength_stream: got %h expected %h", q.obs, q.exp);
            else n_pass++;
        end
    endtask

    task automatic test_gray();
        res_t q;
        mode = 2'd2;
        bright = 4'd3;
        vsync();
        line(4, 8'hC0, 8'h60, 8'h30);
        bright = 4'd9;
        line(4, 8'hC0, 8'h60, 8'h30);
        vsync();
        line(4, 8'hC0, 8'h60, 8'h30);
        line(8, -1, -1, -1);
        while (res_q.size() > 0) begin
            q = res_q.pop_front();
            n_checks++;
            if ((q.obs & q.mask) !== (q.exp & q.mask)) $display("FAIL gray_stream: got %h expected %h", q.obs, q.exp);
            else n_pass++;
        end
    endtask

    task automatic test_mode_switch();
        res_t q;
        mode = 2'd0;
        bright = 4'd0;
        vsync();
        line(8, -1, -1, -1);
        line(8, -1, -1, -1);
        mode = 2'd1;
        line(8, -1, -1, -1);
        line(8, -1, -1, -1);
        vsync();
        for (int l = 0; l < 4; l++) line(8, -1, -1, -1);
        while (res_q.size() > 0) begin
            q = res_q.pop_front();
            n_checks++;
            if ((q.obs & q.mask) !== (q.exp & q.mask)) $display("FAIL mode_switch_stream: got %h expected %h", q.obs, q.exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        res_t q;
        int   nl;
        for (int f = 0; f < 6; f++) begin
            mode   = 2'($urandom);
            bright = 4'($urandom);
            vsync();
            nl = 1 + int'($urandom_range(0, 7));
            for (int l = 0; l < nl; l++) begin
                if ($urandom_range(0, 5) == 0) mode = 2'($urandom);
                line(1 + int'($urandom_range(0, 9)), -1, -1, -1);
            end
        end
        vsync();
        n_checks++;
        if (meas_height !== 16'(m_height) || meas_width !== 16'(m_width) || line_err !== m_err)
            $display("FAIL random_meas: got h=%0d w=%0d err=%b expected h=%0d w=%0d err=%b",
                     meas_height, meas_width, line_err, m_height, m_width, m_err);
        else n_pass++;
        while (res_q.size() > 0) begin
            q = res_q.pop_front();
            n_checks++;
            if ((q.obs & q.mask) !== (q.exp & q.mask)) $display("FAIL random_stream: got %h expected %h", q.obs, q.exp);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        res_t        q;
        logic [14:0] obs;
        mode = 2'd0;
        vsync();
        for (int l = 0; l < 5; l++) line(7, -1, -1, -1);
        vsync();
        n_checks++;
        if (meas_height !== 16'd5) $display("FAIL async_height: got %0d expected 5", meas_height);
        else n_pass++;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 8'hF0, 8'hF0, 8'hF0);
        while (res_q.size() > 0) begin
            q = res_q.pop_front();
            n_checks++;
            if ((q.obs & q.mask) !== (q.exp & q.mask)) $display("FAIL async_pre_stream: got %h expected %h", q.obs, q.exp);
            else n_pass++;
        end
        #1 rst_n = 1'b0;
        #1;
        obs = {vid.out_de, vid.out_hs, vid.out_vs, vid.out_r, vid.out_g, vid.out_b};
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b1, 12'h000}) $display("FAIL async_stream: got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 12'h000});
        else n_pass++;
        n_checks++;
        if ({meas_width, meas_height, line_err} !== 33'd0)
            $display("FAIL async_meas: got w=%0d h=%0d err=%b expected 0 0 0", meas_width, meas_height, line_err);
        else n_pass++;
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        model_reset();
        vid.in_de = 1'b0; vid.in_hs = 1'b1; vid.in_vs = 1'b1;
        line(8, -1, -1, -1);
        repeat (2) tick(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        while (res_q.size() > 0) begin
            q = res_q.pop_front();
            n_checks++;
            if ((q.obs & q.mask) !== (q.exp & q.mask)) $display("FAIL async_post_stream: got %h expected %h", q.obs, q.exp);
            else n_pass++;
        end
    endtask

    initial begin
        vid.in_r = '0; vid.in_g = '0; vid.in_b = '0;
        vid.in_de = 1'b0; vid.in_hs = 1'b1; vid.in_vs = 1'b1;
        model_reset();
        test_reset();
        test_live();
        test_delay();
        test_overlength();
        test_gray();
        test_mode_switch();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
